// File: rtl/layer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_scheduler_pkg
// Description : Shared types and default widths for the SNN layer scheduler:
//               scheduler state encoding and the per-layer config entry.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_scheduler_pkg;

  // Default field widths; the top-level parameters start from these.
  localparam int HW_WIDTH_DEF   = 5;
  localparam int T_WIDTH_DEF    = 5;
  localparam int TPD_WIDTH_DEF  = 4;
  localparam int NUM_LAYERS_DEF = 4;
  localparam int LID_WIDTH_DEF  = 2;
  localparam int DRAIN_CYC_DEF  = 4;

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_t;

  // One config table entry at the default widths (hw = H-1 = W-1, t = T-1).
  typedef struct packed {
    logic [HW_WIDTH_DEF-1:0]  hw;
    logic [T_WIDTH_DEF-1:0]   t;
    logic [TPD_WIDTH_DEF-1:0] tpd;
  } cfg_entry_t;

endpackage : layer_scheduler_pkg
`default_nettype wire

// File: rtl/frame_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_beat_counter
// Description : Nested t/w/h beat counter for one dataflow frame. t is the
//               innermost loop, then w, then h, matching the order the conv
//               dataflow controller consumes beats. last_o flags the final
//               beat (t==T, w==HW, h==HW) of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_beat_counter #(
  parameter int HW_WIDTH = 5,
  parameter int T_WIDTH  = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                adv_i,
  input  logic [HW_WIDTH-1:0] hw_i,
  input  logic [T_WIDTH-1:0]  t_i,
  output logic                last_o
);

  localparam logic [HW_WIDTH-1:0] C_HW_ONE = HW_WIDTH'(1);
  localparam logic [T_WIDTH-1:0]  C_T_ONE  = T_WIDTH'(1);

  logic [T_WIDTH-1:0]  t_q;
  logic [HW_WIDTH-1:0] w_q;
  logic [HW_WIDTH-1:0] h_q;

  logic w_t_wrap;
  logic w_w_wrap;
  logic w_h_wrap;

  assign w_t_wrap = (t_q == t_i);
  assign w_w_wrap = (w_q == hw_i);
  assign w_h_wrap = (h_q == hw_i);
  assign last_o   = w_t_wrap & w_w_wrap & w_h_wrap;

  // Advance the nested counters on each accepted beat; clear wins over advance.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      t_q <= '0;
      w_q <= '0;
      h_q <= '0;
    end else if (adv_i) begin
      if (w_t_wrap) begin
        t_q <= '0;
        if (w_w_wrap) begin
          w_q <= '0;
          h_q <= w_h_wrap ? '0 : h_q + C_HW_ONE;
        end else begin
          w_q <= w_q + C_HW_ONE;
        end
      end else begin
        t_q <= t_q + C_T_ONE;
      end
    end
  end

endmodule : frame_beat_counter
`default_nettype wire

// File: rtl/layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : layer_scheduler
// Description : Walks the SNN conv dataflow controller through a programmed
//               list of layers. Holds a small config table, presents the
//               active entry, gates source beats into IN_VALID for exactly one
//               frame per layer, drives BP between layers and when idle, and
//               reports progress (LAYER/BUSY) and completion (DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int HW_WIDTH   = HW_WIDTH_DEF,
  parameter int T_WIDTH    = T_WIDTH_DEF,
  parameter int TPD_WIDTH  = TPD_WIDTH_DEF,
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int LID_WIDTH  = LID_WIDTH_DEF,
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CFG_WE,
  input  logic [LID_WIDTH-1:0] CFG_ADDR,
  input  logic [HW_WIDTH-1:0]  CFG_HW,
  input  logic [T_WIDTH-1:0]   CFG_T,
  input  logic [TPD_WIDTH-1:0] CFG_TPD,
  input  logic [LID_WIDTH-1:0] CFG_NL,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  output logic                 IN_VALID,
  output logic [HW_WIDTH-1:0]  HW,
  output logic [T_WIDTH-1:0]   T,
  output logic [TPD_WIDTH-1:0] TPD,
  output logic                 BP,
  output logic                 DF_CLR,
  output logic [LID_WIDTH-1:0] LAYER,
  output logic                 BUSY,
  output logic                 DONE
);

  // Drain counter runs 0 .. DRAIN_CYC-1 (DRAIN_CYC is expected to be >= 1).
  localparam int                   C_DCW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [C_DCW-1:0]     C_DRAIN_LAST = C_DCW'(DRAIN_CYC - 1);
  localparam logic [C_DCW-1:0]     C_DRAIN_ONE  = C_DCW'(1);
  localparam logic [LID_WIDTH-1:0] C_LID_ONE    = LID_WIDTH'(1);

  // Config table (deliberately not reset: a run uses whatever was written).
  logic [HW_WIDTH-1:0]  tbl_hw_q  [NUM_LAYERS];
  logic [T_WIDTH-1:0]   tbl_t_q   [NUM_LAYERS];
  logic [TPD_WIDTH-1:0] tbl_tpd_q [NUM_LAYERS];

  sched_state_t         state_q;
  logic [LID_WIDTH-1:0] layer_q;
  logic [LID_WIDTH-1:0] nl_q;
  logic [HW_WIDTH-1:0]  hw_q;
  logic [T_WIDTH-1:0]   t_q;
  logic [TPD_WIDTH-1:0] tpd_q;
  logic [C_DCW-1:0]     drain_cnt_q;
  logic                 src_ready_q;
  logic                 bp_q;
  logic                 df_clr_q;
  logic                 done_q;
  logic                 busy_q;

  logic w_in_valid;
  logic w_abort;
  logic w_cnt_clr;
  logic w_frame_last;

  // SRC_READY is only ever high in STREAM, so every IN_VALID is a frame beat.
  assign w_in_valid = SRC_VALID & src_ready_q;
  assign w_abort    = ABORT & (state_q != ST_IDLE);
  assign w_cnt_clr  = (state_q == ST_LOAD) | w_abort;

  frame_beat_counter #(
    .HW_WIDTH (HW_WIDTH),
    .T_WIDTH  (T_WIDTH)
  ) u_frame_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (w_cnt_clr),
    .adv_i  (w_in_valid),
    .hw_i   (hw_q),
    .t_i    (t_q),
    .last_o (w_frame_last)
  );

  // Config table writes, accepted only while idle.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == ST_IDLE) && CFG_WE) begin
      tbl_hw_q[CFG_ADDR]  <= CFG_HW;
      tbl_t_q[CFG_ADDR]   <= CFG_T;
      tbl_tpd_q[CFG_ADDR] <= CFG_TPD;
    end
  end

  // Layer sequencing FSM with registered outputs; ABORT overrides every busy transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      nl_q        <= '0;
      hw_q        <= '0;
      t_q         <= '0;
      tpd_q       <= '0;
      drain_cnt_q <= '0;
      src_ready_q <= 1'b0;
      bp_q        <= 1'b1;
      df_clr_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      df_clr_q <= 1'b0;
      done_q   <= 1'b0;
      if (w_abort) begin
        state_q     <= ST_IDLE;
        src_ready_q <= 1'b0;
        bp_q        <= 1'b1;
        df_clr_q    <= 1'b1;
        busy_q      <= 1'b0;
        drain_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (START) begin
              state_q <= ST_LOAD;
              nl_q    <= CFG_NL;
              layer_q <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: begin
            hw_q        <= tbl_hw_q[layer_q];
            t_q         <= tbl_t_q[layer_q];
            tpd_q       <= tbl_tpd_q[layer_q];
            drain_cnt_q <= '0;
            bp_q        <= 1'b0;
            src_ready_q <= 1'b1;
            state_q     <= ST_STREAM;
          end
          ST_STREAM: begin
            if (w_in_valid && w_frame_last) begin
              src_ready_q <= 1'b0;
              state_q     <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt_q == C_DRAIN_LAST) begin
              drain_cnt_q <= '0;
              bp_q        <= 1'b1;
              if (layer_q == nl_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                layer_q <= layer_q + C_LID_ONE;
                state_q <= ST_LOAD;
              end
            end else begin
              drain_cnt_q <= drain_cnt_q + C_DRAIN_ONE;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            src_ready_q <= 1'b0;
            bp_q        <= 1'b1;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SRC_READY = src_ready_q;
  assign IN_VALID  = w_in_valid;
  assign HW        = hw_q;
  assign T         = t_q;
  assign TPD       = tpd_q;
  assign BP        = bp_q;
  assign DF_CLR    = df_clr_q;
  assign LAYER     = layer_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule : layer_scheduler
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_scheduler
// Description : Directed self-checking bench for layer_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_scheduler;
  import layer_scheduler_pkg::*;

  localparam int C_DRAIN = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CFG_WE;
  logic [1:0] CFG_ADDR;
  logic [4:0] CFG_HW;
  logic [4:0] CFG_T;
  logic [3:0] CFG_TPD;
  logic [1:0] CFG_NL;
  logic       START;
  logic       ABORT;
  logic       SRC_VALID;
  logic       SRC_READY;
  logic       IN_VALID;
  logic [4:0] HW;
  logic [4:0] T;
  logic [3:0] TPD;
  logic       BP;
  logic       DF_CLR;
  logic [1:0] LAYER;
  logic       BUSY;
  logic       DONE;

  layer_scheduler dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_HW(CFG_HW), .CFG_T(CFG_T), .CFG_TPD(CFG_TPD), .CFG_NL(CFG_NL),
    .START(START), .ABORT(ABORT), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
    .IN_VALID(IN_VALID), .HW(HW), .T(T), .TPD(TPD), .BP(BP), .DF_CLR(DF_CLR),
    .LAYER(LAYER), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Bench-side copy of the config table (only honoured writes land here).
  cfg_entry_t model [4];

  // Event counters sampled at each rising edge.
  int cyc = 0, beats = 0, dones = 0, clrs = 0, load_cyc = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  int beats_l [4] = '{0, 0, 0, 0};

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (IN_VALID === 1'b1) begin
      beats <= beats + 1;
      beats_l[LAYER] <= beats_l[LAYER] + 1;
      last_beat_cyc <= cyc + 1;
    end
    if (DONE === 1'b1) begin
      dones <= dones + 1;
      done_cyc <= cyc + 1;
    end
    if (DF_CLR === 1'b1) clrs <= clrs + 1;
    if (BUSY === 1'b1 && BP === 1'b1) load_cyc <= load_cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [1:0] a, input logic [4:0] hw, input logic [4:0] t,
                           input logic [3:0] tpd);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_HW = hw; CFG_T = t; CFG_TPD = tpd;
    @(posedge CLK); #1;
    CFG_WE = 1'b0;
    model[a] = '{hw: hw, t: t, tpd: tpd};
  endtask

  task automatic do_start(input logic [1:0] nl);
    START = 1'b1; CFG_NL = nl;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Feed the source until BUSY drops (mode 0: always valid, mode 1: 1,0,0,...).
  task automatic run_until_idle(input int mode, output int cfg_bad, output int bp_bad,
                                output bit timeout);
    cfg_bad = 0; bp_bad = 0; timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      SRC_VALID = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      @(posedge CLK); #1;
      if (SRC_READY === 1'b1 && ({HW, T, TPD} !== model[LAYER])) cfg_bad++;
      if (SRC_READY === 1'b1 && BP !== 1'b0) bp_bad++;
      if (BUSY === 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
    SRC_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_HW = '0; CFG_T = '0; CFG_TPD = '0;
    CFG_NL = '0; START = 1'b0; ABORT = 1'b0; SRC_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (SRC_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", SRC_READY); end
    n_cmp++; if (IN_VALID !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got %b want 0", IN_VALID); end
    n_cmp++; if (BP !== 1'b1) begin n_err++; $display("FAIL reset_bp: got %b want 1", BP); end
    n_cmp++; if (DF_CLR !== 1'b0) begin n_err++; $display("FAIL reset_df_clr: got %b want 0", DF_CLR); end
    n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (LAYER !== 2'd0) begin n_err++; $display("FAIL reset_layer: got %0d want 0", LAYER); end
    n_cmp++; if ({HW, T, TPD} !== 14'd0) begin n_err++; $display("FAIL reset_cfg: got %h want 0", {HW, T, TPD}); end
    RST = 1'b0; SRC_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_layer();
    int b0, d0, l0, cb, bb;
    bit to;
    cfg_write(2'd0, 5'd3, 5'd1, 4'd2);
    n_cmp++; if (BP !== 1'b1) begin n_err++; $display("FAIL single_bp_before: got %b want 1", BP); end
    b0 = beats; d0 = dones; l0 = load_cyc;
    do_start(2'd0);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL single_timeout: got %b want 0", to); end
    n_cmp++; if (beats - b0 !== 32) begin n_err++; $display("FAIL single_beats: got %0d want 32", beats - b0); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL single_dones: got %0d want 1", dones - d0); end
    n_cmp++; if (done_cyc - last_beat_cyc !== 1 + C_DRAIN) begin n_err++; $display("FAIL single_done_lat: got %0d want %0d", done_cyc - last_beat_cyc, 1 + C_DRAIN); end
    n_cmp++; if (cb !== 0) begin n_err++; $display("FAIL single_cfg_out: got %0d bad cycles want 0", cb); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL single_bp_stream: got %0d bad cycles want 0", bb); end
    n_cmp++; if (load_cyc - l0 !== 1) begin n_err++; $display("FAIL single_load_cyc: got %0d want 1", load_cyc - l0); end
    n_cmp++; if ({BP, SRC_READY, BUSY} !== 3'b100) begin n_err++; $display("FAIL single_after: got bp/rdy/busy %b want 100", {BP, SRC_READY, BUSY}); end
  endtask

  task automatic test_backpressure();
    int b0, d0, cb, bb;
    bit to;
    b0 = beats; d0 = dones;
    do_start(2'd0);
    run_until_idle(1, cb, bb, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bpress_timeout: got %b want 0", to); end
    n_cmp++; if (beats - b0 !== 32) begin n_err++; $display("FAIL bpress_beats: got %0d want 32", beats - b0); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL bpress_dones: got %0d want 1", dones - d0); end
    n_cmp++; if (done_cyc - last_beat_cyc !== 1 + C_DRAIN) begin n_err++; $display("FAIL bpress_done_lat: got %0d want %0d", done_cyc - last_beat_cyc, 1 + C_DRAIN); end
    n_cmp++; if (cb !== 0) begin n_err++; $display("FAIL bpress_cfg_stable: got %0d bad cycles want 0", cb); end
  endtask

  task automatic test_two_layers();
    int b0, b1, d0, l0, cb, bb;
    bit to;
    cfg_write(2'd0, 5'd1, 5'd0, 4'd1);
    cfg_write(2'd1, 5'd2, 5'd2, 4'd3);
    b0 = beats_l[0]; b1 = beats_l[1]; d0 = dones; l0 = load_cyc;
    do_start(2'd1);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL two_timeout: got %b want 0", to); end
    n_cmp++; if (beats_l[0] - b0 !== 4) begin n_err++; $display("FAIL two_beats_l0: got %0d want 4", beats_l[0] - b0); end
    n_cmp++; if (beats_l[1] - b1 !== 27) begin n_err++; $display("FAIL two_beats_l1: got %0d want 27", beats_l[1] - b1); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL two_dones: got %0d want 1", dones - d0); end
    n_cmp++; if (load_cyc - l0 !== 2) begin n_err++; $display("FAIL two_load_cyc: got %0d want 2", load_cyc - l0); end
    n_cmp++; if (cb !== 0) begin n_err++; $display("FAIL two_cfg_out: got %0d bad cycles want 0", cb); end
    n_cmp++; if ({HW, T, TPD} !== {5'd2, 5'd2, 4'd3}) begin n_err++; $display("FAIL two_last_cfg: got %h want %h", {HW, T, TPD}, {5'd2, 5'd2, 4'd3}); end
    n_cmp++; if (done_cyc - last_beat_cyc !== 1 + C_DRAIN) begin n_err++; $display("FAIL two_done_lat: got %0d want %0d", done_cyc - last_beat_cyc, 1 + C_DRAIN); end
  endtask

  task automatic test_abort();
    int b0, d0, c0, cb, bb;
    bit to, fired;
    cfg_write(2'd0, 5'd3, 5'd1, 4'd2);
    b0 = beats; d0 = dones; c0 = clrs; fired = 1'b0;
    do_start(2'd0);
    for (int i = 0; i < 200 && !fired; i++) begin
      SRC_VALID = 1'b1;
      if (SRC_READY === 1'b1 && beats - b0 == 9) begin
        ABORT = 1'b1;
        fired = 1'b1;
      end
      @(posedge CLK); #1;
    end
    ABORT = 1'b0; SRC_VALID = 1'b0;
    n_cmp++; if (fired !== 1'b1) begin n_err++; $display("FAIL abort_reached: got %b want 1", fired); end
    n_cmp++; if ({BUSY, BP, SRC_READY, DF_CLR, DONE} !== 5'b01010) begin n_err++; $display("FAIL abort_next: got busy/bp/rdy/clr/done %b want 01010", {BUSY, BP, SRC_READY, DF_CLR, DONE}); end
    @(posedge CLK); #1;
    n_cmp++; if (DF_CLR !== 1'b0) begin n_err++; $display("FAIL abort_clr_width: got %b want 0", DF_CLR); end
    n_cmp++; if (beats - b0 !== 10) begin n_err++; $display("FAIL abort_beats: got %0d want 10", beats - b0); end
    n_cmp++; if (dones - d0 !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dones - d0); end
    n_cmp++; if (clrs - c0 !== 1) begin n_err++; $display("FAIL abort_clr_count: got %0d want 1", clrs - c0); end
    // ABORT while idle has no effect
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    n_cmp++; if ({BUSY, DF_CLR} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got busy/clr %b want 00", {BUSY, DF_CLR}); end
    b0 = beats; d0 = dones;
    do_start(2'd0);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 32 || to) begin n_err++; $display("FAIL abort_rerun_beats: got %0d want 32", beats - b0); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL abort_rerun_dones: got %0d want 1", dones - d0); end
  endtask

  task automatic test_cfg_while_busy();
    int b0, d0, l0, cb, bb;
    bit to;
    b0 = beats; d0 = dones; l0 = load_cyc;
    do_start(2'd0);
    repeat (5) begin SRC_VALID = 1'b1; @(posedge CLK); #1; end
    CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_HW = 5'd0; CFG_T = 5'd0; CFG_TPD = 4'd9;
    START = 1'b1; CFG_NL = 2'd3;
    @(posedge CLK); #1;
    CFG_WE = 1'b0; START = 1'b0; CFG_NL = 2'd0;
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 32 || to) begin n_err++; $display("FAIL busy_write_beats: got %0d want 32", beats - b0); end
    n_cmp++; if (load_cyc - l0 !== 1) begin n_err++; $display("FAIL busy_start_ignored: got %0d loads want 1", load_cyc - l0); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL busy_dones: got %0d want 1", dones - d0); end
    b0 = beats;
    do_start(2'd0);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 32 || cb !== 0) begin n_err++; $display("FAIL busy_table_kept: got %0d beats %0d bad cfg want 32 0", beats - b0, cb); end
    // write and start in the same idle cycle
    b0 = beats;
    CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_HW = 5'd1; CFG_T = 5'd1; CFG_TPD = 4'd5;
    START = 1'b1; CFG_NL = 2'd0;
    @(posedge CLK); #1;
    CFG_WE = 1'b0; START = 1'b0;
    model[0] = '{hw: 5'd1, t: 5'd1, tpd: 4'd5};
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 8 || to) begin n_err++; $display("FAIL same_cycle_beats: got %0d want 8", beats - b0); end
    n_cmp++; if ({HW, T, TPD} !== {5'd1, 5'd1, 4'd5} || cb !== 0) begin n_err++; $display("FAIL same_cycle_cfg: got %h want %h", {HW, T, TPD}, {5'd1, 5'd1, 4'd5}); end
  endtask

  task automatic test_reset_mid_stream();
    int b0, cb, bb;
    bit to;
    cfg_write(2'd0, 5'd3, 5'd1, 4'd2);
    do_start(2'd0);
    repeat (6) begin SRC_VALID = 1'b1; @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if ({SRC_READY, BP, BUSY, DONE, DF_CLR} !== 5'b01000) begin n_err++; $display("FAIL rst_mid_ctrl: got rdy/bp/busy/done/clr %b want 01000", {SRC_READY, BP, BUSY, DONE, DF_CLR}); end
    n_cmp++; if ({LAYER, HW, T, TPD} !== 16'd0) begin n_err++; $display("FAIL rst_mid_cfg: got %h want 0", {LAYER, HW, T, TPD}); end
    RST = 1'b0; SRC_VALID = 1'b0;
    @(posedge CLK); #1;
    b0 = beats;
    do_start(2'd0);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 32 || cb !== 0 || to) begin n_err++; $display("FAIL rst_mid_table_kept: got %0d beats %0d bad cfg want 32 0", beats - b0, cb); end
  endtask

  task automatic test_min_frame();
    int b0, d0, cb, bb;
    bit to;
    cfg_write(2'd0, 5'd0, 5'd0, 4'd7);
    b0 = beats; d0 = dones;
    do_start(2'd0);
    run_until_idle(0, cb, bb, to);
    n_cmp++; if (beats - b0 !== 1 || to) begin n_err++; $display("FAIL min_beats: got %0d want 1", beats - b0); end
    n_cmp++; if (dones - d0 !== 1) begin n_err++; $display("FAIL min_dones: got %0d want 1", dones - d0); end
    n_cmp++; if (done_cyc - last_beat_cyc !== 1 + C_DRAIN) begin n_err++; $display("FAIL min_done_lat: got %0d want %0d", done_cyc - last_beat_cyc, 1 + C_DRAIN); end
    n_cmp++; if (TPD !== 4'd7 || cb !== 0) begin n_err++; $display("FAIL min_cfg: got tpd %0d want 7", TPD); end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_backpressure();
    test_two_layers();
    test_abort();
    test_cfg_while_busy();
    test_reset_mid_stream();
    test_min_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_layer_scheduler
`default_nettype wire

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences the SNN conv dataflow controller through a programmed list of layers.
- Holds a small per-layer config table (HW, T, TPD) and presents the active entry to the dataflow controller.
- Gates the input source into IN_VALID beats with a valid/ready handshake, counting exactly one frame of (HW+1)^2*(T+1) beats per layer.
- Drives BP to force power-down between layers and when idle, and reports layer progress and completion.

Parameters:
HW_WIDTH, 5, width of H-1/W-1 fields
T_WIDTH, 5, width of T-1 field
TPD_WIDTH, 4, width of power-down delay field
NUM_LAYERS, 4, config table depth
LID_WIDTH, 2, layer index width (clog2 NUM_LAYERS)
DRAIN_CYC, 4, flush cycles after last beat of a layer before switching config

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
CFG_WE  in  1  write config table entry (honoured only in IDLE)
CFG_ADDR  in  LID_WIDTH  entry index
CFG_HW  in  HW_WIDTH  H-1 (=W-1) for entry
CFG_T  in  T_WIDTH  T-1 for entry
CFG_TPD  in  TPD_WIDTH  power-down delay for entry
CFG_NL  in  LID_WIDTH  number of layers minus 1, sampled at START
START  in  1  begin run (honoured only in IDLE)
ABORT  in  1  terminate run
SRC_VALID  in  1  source beat available
SRC_READY  out  1  scheduler accepting beats
IN_VALID  out  1  beat to dataflow = SRC_VALID & SRC_READY
HW  out  HW_WIDTH  active layer H-1
T  out  T_WIDTH  active layer T-1
TPD  out  TPD_WIDTH  active layer TPD
BP  out  1  force dataflow power-down
DF_CLR  out  1  one-cycle pulse to clear dataflow counters (top level merges into its reset)
LAYER  out  LID_WIDTH  active layer index
BUSY  out  1  high in any state except IDLE
DONE  out  1  one-cycle pulse after last layer drains

Behaviour:
- Reset (RST high at posedge): state IDLE, SRC_READY=0, BP=1, DF_CLR=0, DONE=0, LAYER=0, HW/T/TPD=0, NL=0, beat counters t/w/h=0. Config table contents are not reset; a run uses whatever was written.
- IN_VALID is combinational: SRC_VALID & SRC_READY. All other outputs are registered.
- FSM states:
  - IDLE: BP=1. CFG_WE writes table[CFG_ADDR]. START -> LOAD; NL<=CFG_NL; LAYER<=0.
  - LOAD (1 cycle): HW/T/TPD <= table[LAYER]; t/w/h<=0; BP=1 -> STREAM.
  - STREAM: BP=0, SRC_READY=1. Each accepted beat advances t (wraps at T), then w (wraps at HW), then h, using the same nested order as the dataflow controller. When the beat with t==T, w==HW, h==HW is accepted -> DRAIN; SRC_READY is 0 from the next cycle.
  - DRAIN: BP=0, SRC_READY=0; wait DRAIN_CYC cycles. If LAYER==NL: DONE pulse, -> IDLE. Else LAYER+1, -> LOAD.
- HW/T/TPD change only in LOAD; they are stable throughout STREAM and DRAIN.
- Zero-beat gaps (SRC_VALID low) in STREAM: counters hold, no timeout.
- ABORT has priority over every transition in any non-IDLE state: next cycle state IDLE, SRC_READY=0, BP=1, DF_CLR=1 for exactly one cycle, no DONE. A beat presented in the ABORT cycle is still counted as IN_VALID (the combinational path), then discarded by DF_CLR.
- ABORT in IDLE: ignored. START while BUSY: ignored. CFG_WE while BUSY: ignored; the table is unchanged.
- START and CFG_WE in the same IDLE cycle: the write lands first; the run starts with the updated table (LOAD reads next cycle).
- Minimum case HW=0, T=0: 1 beat per layer.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, STREAM, DRAIN), default widths, and a config-entry struct {hw, t, tpd}.
- One natural sub-module: frame_beat_counter (nested t/w/h counter with clear/advance inputs and a last-beat flag), reusable by other dataflow-side blocks.

Test Plan:
- Single layer: table[0]={HW=3,T=1,TPD=2}, NL=0, SRC_VALID constant 1 -> exactly 32 IN_VALID beats, SRC_READY falls after beat 32, DONE pulses 1+DRAIN_CYC cycles after last beat, BP high before and after.
- Backpressure: same config, SRC_VALID toggling 1,0,0,1... -> still 32 IN_VALID, counters hold during gaps, HW/T/TPD stable.
- Two layers: table[0]={1,0,1}, table[1]={2,2,3}, NL=1 -> 4 beats, drain, LOAD with BP=1 for one cycle, LAYER=1, outputs {2,2,3}, 27 beats, single DONE.
- Abort at beat 10 of a 32-beat layer -> next cycle IDLE, DF_CLR one-cycle pulse, BP=1, no DONE, BUSY=0; a following START runs a full frame from t=w=h=0.
- CFG_WE to entry 0 and START during STREAM -> table and run unaffected; CFG_WE plus START in the same IDLE cycle -> run uses the new value.
- Reset asserted mid-STREAM -> next cycle all outputs at reset values; table entries retained.
